// File: rtl/sum_accumulator.sv
// -----------------------------------------------------------------------------
// sum_accumulator
//
// Accumulates a run of 5-bit terms ({cout_in, sum_in}) coming from an upstream
// 4-bit adder into an ACC_W-bit accumulator, under a valid/ready handshake.
// A run starts with start in IDLE, accepts num_terms handshakes in ACCUM,
// then presents the result in DONE until the consumer takes it.
//
// Parameters:
//   ACC_W       accumulator width in bits (6..16), default 8
//
// Ports:
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   start       begin a run (sampled only in IDLE)
//   num_terms   number of terms in the run, captured on accepted start
//   sum_in      sum bits S[3:0] of the upstream adder
//   cout_in     carry-out of the upstream adder
//   in_valid    term on sum_in/cout_in is valid
//   in_ready    block accepts a term this cycle (ACCUM only)
//   acc         running / final accumulated value
//   overflow    sticky: the run exceeded 2^ACC_W-1
//   done_valid  acc holds the final result of the run
//   done_ready  consumer takes the result
//
// Configuration macro:
//   SUM_ACC_SAT_EN  defined   -> acc saturates at 2^ACC_W-1 on overflow
//                   undefined -> acc wraps modulo 2^ACC_W on overflow
//   overflow is set in both builds and held until the next accepted start.
// -----------------------------------------------------------------------------
module sum_accumulator #(
    parameter int unsigned ACC_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       num_terms,
    input  logic [3:0]       sum_in,
    input  logic             cout_in,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [ACC_W-1:0] acc,
    output logic             overflow,
    output logic             done_valid,
    input  logic             done_ready
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       cnt_q;
    logic [3:0]       nterms_q;
    logic [ACC_W-1:0] acc_q;
    logic             ovf_q;

    logic             hs;
    logic             last_term;
    logic [ACC_W:0]   sum_ext;
    logic             carry;
    logic [ACC_W-1:0] acc_next;

    // Term is zero-extended to ACC_W+1 so the top bit is the add's carry-out.
    assign sum_ext   = {1'b0, acc_q} + {{(ACC_W-4){1'b0}}, cout_in, sum_in};
    assign carry     = sum_ext[ACC_W];
    assign hs        = in_valid && in_ready;
    // cnt_q < nterms_q while in ACCUM, so the 4-bit increment cannot wrap here.
    assign last_term = ((cnt_q + 4'd1) == nterms_q);

`ifdef SUM_ACC_SAT_EN
    assign acc_next = carry ? '1 : sum_ext[ACC_W-1:0];
`else
    assign acc_next = sum_ext[ACC_W-1:0];
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and handshake outputs
    always_comb begin
        state_d    = state_q;
        in_ready   = 1'b0;
        done_valid = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = (num_terms == 4'd0) ? DONE : ACCUM;
                end
            end
            ACCUM: begin
                in_ready = 1'b1;
                if (in_valid && last_term) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                done_valid = 1'b1;
                if (done_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Datapath: accumulator, sticky overflow, term counter, captured length
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q    <= '0;
            ovf_q    <= 1'b0;
            cnt_q    <= '0;
            nterms_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        acc_q    <= '0;
                        ovf_q    <= 1'b0;
                        cnt_q    <= '0;
                        nterms_q <= num_terms;
                    end
                end
                ACCUM: begin
                    if (hs) begin
                        acc_q <= acc_next;
                        ovf_q <= ovf_q | carry;
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                default: begin
                    // DONE holds acc/overflow stable for the consumer
                end
            endcase
        end
    end

    assign acc      = acc_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_sum_accumulator.sv
module tb_sum_accumulator;

    localparam int unsigned ACC_W = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [3:0]       num_terms;
    logic [3:0]       sum_in;
    logic             cout_in;
    logic             in_valid;
    logic             in_ready;
    logic [ACC_W-1:0] acc;
    logic             overflow;
    logic             done_valid;
    logic             done_ready;

    int checks = 0;
    int errors = 0;

    sum_accumulator #(.ACC_W(ACC_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .num_terms  (num_terms),
        .sum_in     (sum_in),
        .cout_in    (cout_in),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .acc        (acc),
        .overflow   (overflow),
        .done_valid (done_valid),
        .done_ready (done_ready)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Presents one term and waits (bounded) for it to be accepted.
    task automatic feed(input string tag, input logic [4:0] v);
        int n;
        n = 0;
        in_valid = 1'b1;
        {cout_in, sum_in} = v;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        checks++;
        assert (n < 20) else begin
            errors++;
            $error("FAIL %s: observed in_ready timeout expected handshake", tag);
        end
        tick();
        in_valid = 1'b0;
        {cout_in, sum_in} = 5'd0;
    endtask

    task automatic begin_run(input logic [3:0] n);
        start = 1'b1;
        num_terms = n;
        tick();
        start = 1'b0;
        num_terms = 4'd0;
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        num_terms = 4'd0;
        sum_in = 4'd0;
        cout_in = 1'b0;
        in_valid = 1'b0;
        done_ready = 1'b0;

        // Reset state
        #2;
        chk("rst_acc", 32'(acc), 0);
        chk("rst_ovf", 32'(overflow), 0);
        chk("rst_in_ready", 32'(in_ready), 0);
        chk("rst_done_valid", 32'(done_valid), 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Basic run: 1 + 7 + 17 + 9 = 34
        begin_run(4'd4);
        chk("basic_in_ready", 32'(in_ready), 1);
        chk("basic_acc0", 32'(acc), 0);
        feed("basic_t1", 5'd1);
        chk("basic_acc1", 32'(acc), 1);
        feed("basic_t2", 5'd7);
        chk("basic_acc2", 32'(acc), 8);
        feed("basic_t3", 5'd17);
        chk("basic_acc3", 32'(acc), 25);
        chk("basic_not_done3", 32'(done_valid), 0);
        feed("basic_t4", 5'd9);
        chk("basic_done", 32'(done_valid), 1);
        chk("basic_acc", 32'(acc), 34);
        chk("basic_ovf", 32'(overflow), 0);
        chk("basic_done_in_ready", 32'(in_ready), 0);
        done_ready = 1'b1;
        tick();
        done_ready = 1'b0;
        chk("basic_idle", 32'(done_valid), 0);
        chk("basic_idle_acc_hold", 32'(acc), 34);

        // Zero-length run with 5 cycles of backpressure in DONE
        start = 1'b1;
        num_terms = 4'd0;
        chk("zero_in_ready_idle", 32'(in_ready), 0);
        tick();
        start = 1'b0;
        chk("zero_done", 32'(done_valid), 1);
        chk("zero_acc", 32'(acc), 0);
        chk("zero_in_ready", 32'(in_ready), 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_done_valid", 32'(done_valid), 1);
            chk("bp_acc", 32'(acc), 0);
            chk("bp_in_ready", 32'(in_ready), 0);
        end
        done_ready = 1'b1;
        tick();
        done_ready = 1'b0;
        chk("bp_released", 32'(done_valid), 0);

        // Overflow: ten terms of 31 = 310
        begin_run(4'd10);
        for (int i = 0; i < 10; i++) begin
            feed("ovf_term", 5'd31);
        end
        chk("ovf_done", 32'(done_valid), 1);
`ifdef SUM_ACC_SAT_EN
        chk("ovf_acc", 32'(acc), 255);
`else
        chk("ovf_acc", 32'(acc), 54);
`endif
        chk("ovf_flag", 32'(overflow), 1);
        done_ready = 1'b1;
        tick();
        done_ready = 1'b0;
        tick();
        chk("ovf_sticky_idle", 32'(overflow), 1);

        // New start clears overflow; in_valid gaps change nothing
        begin_run(4'd2);
        chk("stall_ovf_cleared", 32'(overflow), 0);
        chk("stall_acc_cleared", 32'(acc), 0);
        feed("stall_t1", 5'd3);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_acc", 32'(acc), 3);
            chk("stall_in_ready", 32'(in_ready), 1);
            chk("stall_not_done", 32'(done_valid), 0);
        end
        feed("stall_t2", 5'd4);
        chk("stall_done", 32'(done_valid), 1);
        chk("stall_final", 32'(acc), 7);
        done_ready = 1'b1;
        tick();
        done_ready = 1'b0;

        // Ignored start during ACCUM: still needs three handshakes
        begin_run(4'd3);
        feed("ign_t1", 5'd5);
        start = 1'b1;
        num_terms = 4'd2;
        tick();
        start = 1'b0;
        num_terms = 4'd0;
        chk("ign_acc_kept", 32'(acc), 5);
        feed("ign_t2", 5'd10);
        chk("ign_not_done2", 32'(done_valid), 0);
        chk("ign_in_ready2", 32'(in_ready), 1);
        feed("ign_t3", 5'd20);
        chk("ign_done3", 32'(done_valid), 1);
        chk("ign_acc", 32'(acc), 35);
        done_ready = 1'b1;
        tick();
        done_ready = 1'b0;

        // Mid-run reset between clock edges
        begin_run(4'd5);
        feed("mrst_t1", 5'd3);
        feed("mrst_t2", 5'd4);
        chk("mrst_acc_pre", 32'(acc), 7);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mrst_acc", 32'(acc), 0);
        chk("mrst_in_ready", 32'(in_ready), 0);
        chk("mrst_done_valid", 32'(done_valid), 0);
        tick();
        #2;
        rst_n = 1'b1;
        tick();
        chk("mrst_idle", 32'(in_ready), 0);
        begin_run(4'd1);
        feed("mrst_new_t1", 5'd6);
        chk("mrst_new_done", 32'(done_valid), 1);
        chk("mrst_new_acc", 32'(acc), 6);
        done_ready = 1'b1;
        tick();
        done_ready = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sum_accumulator.md
SUM_ACCUMULATOR -- requirements
Module: sum_accumulator

Interface
REQ-001 The module SHALL have one parameter: ACC_W, default 8, accumulator width in bits, legal range 6..16.
REQ-002 The module SHALL have port clk, input, 1 bit: single clock, rising-edge active.
REQ-003 The module SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The module SHALL have port start, input, 1 bit: begins an accumulation run; sampled only in IDLE.
REQ-005 The module SHALL have port num_terms, input, 4 bits: number of terms in the run; captured on accepted start.
REQ-006 The module SHALL have port sum_in, input, 4 bits: sum bits S[3:0] from the upstream 4-bit adder.
REQ-007 The module SHALL have port cout_in, input, 1 bit: final carry-out from the upstream adder.
REQ-008 The module SHALL have port in_valid, input, 1 bit: the term on sum_in/cout_in is valid.
REQ-009 The module SHALL have port in_ready, output, 1 bit: the block accepts a term this cycle.
REQ-010 The module SHALL have port acc, output, ACC_W bits: running and final accumulated value.
REQ-011 The module SHALL have port overflow, output, 1 bit: sticky flag, set when the run exceeds 2^ACC_W-1.
REQ-012 The module SHALL have port done_valid, output, 1 bit: acc holds the final result of the run.
REQ-013 The module SHALL have port done_ready, input, 1 bit: the consumer takes the result.

Function
REQ-014 The term value SHALL be the 5-bit value {cout_in, sum_in}, range 0..31, zero-extended to ACC_W.
REQ-015 The FSM SHALL have three states: IDLE, ACCUM and DONE, and SHALL power up in IDLE.
REQ-016 In IDLE, start=1 with num_terms!=0 SHALL clear acc and overflow, clear the term counter, capture num_terms, and go to ACCUM on the next edge.
REQ-017 In IDLE, start=1 with num_terms=0 SHALL clear acc and overflow and go directly to DONE on the next edge.
REQ-018 in_ready SHALL be 1 only in ACCUM; it SHALL be 0 in IDLE and DONE.
REQ-019 A handshake (in_valid && in_ready) SHALL add the term to acc at that edge, so the new acc is visible the following cycle; the term counter SHALL increment by 1.
REQ-020 In ACCUM, in_valid=0 SHALL hold acc and the counter unchanged, with no timeout.
REQ-021 The handshake that makes the counter equal the captured num_terms SHALL move the FSM to DONE at the same edge, so done_valid=1 is seen one cycle after the last handshake.
REQ-022 In DONE, done_valid SHALL be 1 and acc and overflow SHALL be stable until done_valid && done_ready; the FSM SHALL then return to IDLE on the next edge.
REQ-023 start SHALL be ignored in ACCUM and DONE; num_terms changes after capture SHALL have no effect.
REQ-024 In IDLE, acc and overflow SHALL keep the last result until the next accepted start.

Reset
REQ-025 rst_n=0 SHALL immediately, without waiting for clk, force the FSM to IDLE and set acc=0, overflow=0, counter=0, in_ready=0 and done_valid=0, including mid-ACCUM or in DONE.
REQ-026 After rst_n rises, the block SHALL act only on the first rising clk edge at which rst_n=1.

Configuration
REQ-027 Macro SUM_ACC_SAT_EN SHALL select the overflow behaviour.
- Defined: a term that would exceed 2^ACC_W-1 SHALL clamp acc to 2^ACC_W-1, and overflow SHALL be set.
- Undefined: acc SHALL wrap modulo 2^ACC_W, and overflow SHALL be set.
- In both builds, overflow SHALL remain set until the next accepted start or reset.

Verification (ACC_W=8)
REQ-028 Basic run: start with num_terms=4; feed terms {cout,sum} = 1, 7, 17 and 9 (adder cases 1+0+0, 2+4+1, B+6+0, 5+3+1) -> acc=34, overflow=0, done_valid=1 one cycle after the 4th handshake.
REQ-029 Zero-length run: start with num_terms=0 -> DONE on the next cycle, acc=0, in_ready never 1.
REQ-030 Overflow: num_terms=10, every term 31 (total 310) -> without SUM_ACC_SAT_EN, acc=54 and overflow=1; with it, acc=255 and overflow=1.
REQ-031 Stalls and backpressure: in_valid gaps of 3 cycles change neither acc nor the count; done_ready held low 5 cycles in DONE keeps done_valid=1 with acc stable and in_ready=0; one cycle with done_ready=1 gives IDLE on the next edge.
REQ-032 Mid-run reset: assert rst_n=0 between clock edges after 2 handshakes -> acc=0 and in_ready=0 immediately; a new start after release runs normally.
REQ-033 Ignored start: pulse start with num_terms=2 during ACCUM of a 3-term run -> the run still completes after exactly 3 handshakes.
